// File: rtl/sm_ifetch_pkg.sv
// sm_ifetch shared types: fetch FSM state encodings, default reset PC
// and the {pc, instr} entry held in the prefetch FIFO.
package sm_ifetch_pkg;

   typedef enum logic [1:0] {
      SM_IF_BOOT  = 2'd0,
      SM_IF_RUN   = 2'd1,
      SM_IF_DRAIN = 2'd2
   } sm_if_state_e;

   localparam logic [31:0] SM_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } sm_if_entry_t;

endpackage

// File: rtl/sm_ifetch_if.sv
// sm_ifetch bus bundle: core side (redirect, instr valid/ready) and
// memory side (req/gnt/addr, rvalid/rdata). master = fetch stage.
interface sm_ifetch_if;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      input  redirect, redirect_pc, instr_ready,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output instr_valid, instr, instr_pc,
      output mem_req, mem_addr
   );

   modport slave (
      output redirect, redirect_pc, instr_ready,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  instr_valid, instr, instr_pc,
      input  mem_req, mem_addr
   );

endinterface

// File: rtl/sm_ifetch_fifo.sv
// sm_ifetch_fifo: synchronous FIFO, W bits x D entries (D power of two).
// Ports: clk, rst, push_i, pop_i, clear_i, din_i, dout_o, count_o, empty_o, full_o.
module sm_ifetch_fifo #(
   parameter int W = 32,
   parameter int D = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [W-1:0]     din_i,
   output logic [W-1:0]     dout_o,
   output logic [$clog2(D):0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(D);

   logic [W-1:0]  mem_q [D];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(D));
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rp_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else if (clear_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + AW'(1);
         if (do_pop)  rp_q <= rp_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= din_i;
   end

endmodule

// File: rtl/sm_ifetch.sv
// sm_ifetch: credit-limited instruction prefetch with in-order FIFO and redirect kill.
// Ports: clk, rst, ifc (sm_ifetch_if.master). Optional macro: SM_IFETCH_BYPASS_EN.
module sm_ifetch
   import sm_ifetch_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = SM_RESET_PC
) (
   input  logic         clk,
   input  logic         rst,
   sm_ifetch_if.master  ifc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   sm_if_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] kill_q, kill_d;

   logic          xfer, rvalid, keep, byp;
   logic [31:0]   pcq_head;
   logic [CW-1:0] pcq_cnt, ff_cnt;
   logic          pcq_empty, pcq_full, ff_empty, ff_full;
   logic          ff_push, ff_pop, out_v;
   logic [CW:0]   used;
   sm_if_entry_t  ff_head, out_e;
   logic          unused_ok;

   assign xfer   = ifc.mem_req & ifc.mem_gnt;
   assign rvalid = ifc.mem_rvalid;
   assign keep   = rvalid & (kill_q == '0);

   // Credits: buffered plus outstanding never exceed the FIFO depth.
   assign used         = {1'b0, ff_cnt} + {1'b0, inflight_q};
   assign ifc.mem_req  = (state_q != SM_IF_BOOT) &&
                         (used < (CW+1)'(FIFO_DEPTH));
   assign ifc.mem_addr = fetch_pc_q;

`ifdef SM_IFETCH_BYPASS_EN
   assign byp   = ff_empty & keep;
   assign out_e = ff_empty ? {pcq_head, ifc.mem_rdata} : ff_head;
`else
   assign byp   = 1'b0;
   assign out_e = ff_head;
`endif

   assign out_v   = ~ff_empty | byp;
   assign ff_pop  = ~ff_empty & ifc.instr_ready & ~ifc.redirect;
   assign ff_push = keep & ~ifc.redirect & ~(byp & ifc.instr_ready);

   assign ifc.instr_valid = out_v;
   assign ifc.instr       = out_v ? out_e.instr : '0;
   assign ifc.instr_pc    = out_v ? out_e.pc : '0;

   sm_ifetch_fifo #(.W(32), .D(FIFO_DEPTH)) u_pcq (
      .clk     (clk),
      .rst     (rst),
      .push_i  (xfer),
      .pop_i   (rvalid),
      .clear_i (1'b0),
      .din_i   (fetch_pc_q),
      .dout_o  (pcq_head),
      .count_o (pcq_cnt),
      .empty_o (pcq_empty),
      .full_o  (pcq_full)
   );

   sm_ifetch_fifo #(.W(64), .D(FIFO_DEPTH)) u_ififo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ff_push),
      .pop_i   (ff_pop),
      .clear_i (ifc.redirect),
      .din_i   ({pcq_head, ifc.mem_rdata}),
      .dout_o  (ff_head),
      .count_o (ff_cnt),
      .empty_o (ff_empty),
      .full_o  (ff_full)
   );

   assign unused_ok = &{1'b0, pcq_cnt, pcq_empty, pcq_full, ff_full};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q + CW'(xfer) - CW'(rvalid);
      kill_d     = kill_q;
      state_d    = state_q;
      if (xfer) fetch_pc_d = fetch_pc_q + 32'd1;
      if (rvalid && kill_q != '0) kill_d = kill_q - CW'(1);
      // Everything still outstanding after this cycle belongs to the old stream.
      if (ifc.redirect) begin
         fetch_pc_d = ifc.redirect_pc;
         kill_d     = inflight_d;
      end
      unique case (state_q)
         SM_IF_BOOT: state_d = SM_IF_RUN;
         SM_IF_RUN, SM_IF_DRAIN:
            state_d = (kill_d != '0) ? SM_IF_DRAIN : SM_IF_RUN;
         default: state_d = SM_IF_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SM_IF_BOOT;
         fetch_pc_q <= RESET_PC;
         inflight_q <= '0;
         kill_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
      end
   end

endmodule
